text_attrib_gen: RTL and testbench

//  Parametrised, pipelined character-attribute decoder for the text-mode video path.

---
 rtl/text_attrib_gen.sv | 124 ++++++++++++
 tb/tb_text_attrib_gen.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/text_attrib_gen.sv
// Text-mode character attribute decoder: font pixel + attribute + cursor/blink -> MDA mono or
// CGA RGBI, one register stage. Cursor and character blink phases are derived from vsync.
module text_attrib_gen #(
  parameter int unsigned UNDERLINE_ROW  = 12,
  parameter int unsigned CURSOR_FRAMES  = 8,
  parameter int unsigned CHAR_BLINK_DIV = 2,
  parameter int unsigned ROW_W          = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode_cga,
  input  logic [7:0]       att_byte,
  input  logic [ROW_W-1:0] row_addr,
  input  logic             display_enable,
  input  logic             blink_enabled,
  input  logic             vsync,
  input  logic             cursor,
  input  logic             pix_in,
  output logic             pix_out,
  output logic             intensity_out,
  output logic [3:0]       rgbi_out,
  output logic             cursor_phase
);

  localparam int unsigned FrameW = (CURSOR_FRAMES > 1) ? $clog2(CURSOR_FRAMES) : 1;
  localparam int unsigned DivW   = (CHAR_BLINK_DIV > 1) ? $clog2(CHAR_BLINK_DIV) : 1;
  localparam logic [FrameW-1:0] FrameLast = FrameW'(CURSOR_FRAMES - 1);
  localparam logic [DivW-1:0]   DivLast   = DivW'(CHAR_BLINK_DIV - 1);
  localparam logic [ROW_W-1:0]  UlRow     = ROW_W'(UNDERLINE_ROW);

  logic [1:0]        vs_hist_q, vs_hist_d;
  logic [FrameW-1:0] frame_cnt_q, frame_cnt_d;
  logic [DivW-1:0]   div_cnt_q, div_cnt_d;
  logic              cursor_phase_q, cursor_phase_d;
  logic              char_phase_q, char_phase_d;
  logic              pix_q, pix_d;
  logic              inten_q, inten_d;
  logic [3:0]        rgbi_q, rgbi_d;

  logic vs_rise, frame_wrap, cursor_rise;

  // Blink phase generation
  always_comb begin
    vs_hist_d      = {vs_hist_q[0], vsync};
    frame_cnt_d    = frame_cnt_q;
    div_cnt_d      = div_cnt_q;
    cursor_phase_d = cursor_phase_q;
    char_phase_d   = char_phase_q;
    vs_rise        = (vs_hist_q == 2'b01);
    frame_wrap     = vs_rise && (frame_cnt_q == FrameLast);
    cursor_rise    = frame_wrap && !cursor_phase_q;
    if (vs_rise) begin
      frame_cnt_d = frame_wrap ? '0 : frame_cnt_q + 1'b1;
    end
    if (frame_wrap) begin
      cursor_phase_d = ~cursor_phase_q;
    end
    if (cursor_rise) begin
      if (div_cnt_q == DivLast) begin
        div_cnt_d    = '0;
        char_phase_d = ~char_phase_q;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end
  end

  // Pixel decode; uses the phases held before this edge
  always_comb begin
    logic cursorblink, blink_area, underline, nodisp, inverse, dots;
    cursorblink = cursor & cursor_phase_q;
    blink_area  = att_byte[7] & char_phase_q & ~cursor & blink_enabled;
    underline   = (att_byte[2:0] == 3'b001) && (row_addr == UlRow);
    nodisp      = (att_byte[2:0] == 3'b000) && (att_byte[6:4] == 3'b000);
    inverse     = (att_byte[2:0] == 3'b000) && (att_byte[6:4] == 3'b111);
    pix_d       = 1'b0;
    inten_d     = 1'b0;
    rgbi_d      = 4'h0;
    if (!mode_cga) begin
      dots    = ((pix_in | underline) & ~nodisp & ~blink_area) | cursorblink;
      pix_d   = dots ^ inverse;
      inten_d = dots ? att_byte[3] : (att_byte[7] & ~blink_enabled);
      rgbi_d  = {inten_d, pix_d, pix_d, pix_d};
    end else begin
      dots    = (pix_in & ~blink_area) | cursorblink;
      rgbi_d  = dots ? att_byte[3:0] : {att_byte[7] & ~blink_enabled, att_byte[6:4]};
      pix_d   = dots;
      inten_d = rgbi_d[3];
    end
    if (!display_enable) begin
      pix_d   = 1'b0;
      inten_d = 1'b0;
      rgbi_d  = 4'h0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_hist_q      <= 2'b00;
      frame_cnt_q    <= '0;
      div_cnt_q      <= '0;
      cursor_phase_q <= 1'b0;
      char_phase_q   <= 1'b0;
      pix_q          <= 1'b0;
      inten_q        <= 1'b0;
      rgbi_q         <= 4'h0;
    end else begin
      vs_hist_q      <= vs_hist_d;
      frame_cnt_q    <= frame_cnt_d;
      div_cnt_q      <= div_cnt_d;
      cursor_phase_q <= cursor_phase_d;
      char_phase_q   <= char_phase_d;
      pix_q          <= pix_d;
      inten_q        <= inten_d;
      rgbi_q         <= rgbi_d;
    end
  end

  assign pix_out       = pix_q;
  assign intensity_out = inten_q;
  assign rgbi_out      = rgbi_q;
  assign cursor_phase  = cursor_phase_q;

endmodule

// File: tb/tb_text_attrib_gen.sv
// Bench for text_attrib_gen: directed cases plus random stimulus against a behavioural model
// that derives blink phases from a count of vsync rising edges.
module tb_text_attrib_gen;

  localparam int unsigned CF  = 8;
  localparam int unsigned DIV = 2;

  logic       clk, reset, mode_cga, display_enable, blink_enabled, vsync, cursor, pix_in;
  logic [7:0] att_byte;
  logic [4:0] row_addr;
  logic       pix_out, intensity_out, cursor_phase;
  logic [3:0] rgbi_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: confirmed rising edges, edge waiting for detection, last vsync sample
  int   edges;
  bit   pending;
  logic last_v;

  text_attrib_gen #(
    .UNDERLINE_ROW (12),
    .CURSOR_FRAMES (CF),
    .CHAR_BLINK_DIV(DIV),
    .ROW_W         (5)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mode_cga      (mode_cga),
    .att_byte      (att_byte),
    .row_addr      (row_addr),
    .display_enable(display_enable),
    .blink_enabled (blink_enabled),
    .vsync         (vsync),
    .cursor        (cursor),
    .pix_in        (pix_in),
    .pix_out       (pix_out),
    .intensity_out (intensity_out),
    .rgbi_out      (rgbi_out),
    .cursor_phase  (cursor_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_cphase();
    return ((edges / CF) % 2) == 1;
  endfunction

  // Cursor phase rises at edges CF, 3CF, 5CF...; char phase toggles every DIV of those.
  function automatic bit model_chphase();
    int rises;
    rises = ((edges / CF) + 1) / 2;
    return ((rises / DIV) % 2) == 1;
  endfunction

  function automatic logic [5:0] model_out(input bit cp, input bit chp);
    logic cb, bl, ul, nd, inv, dots, p, i;
    logic [3:0] c;
    if (!display_enable) return 6'h00;
    cb = cursor & cp;
    bl = att_byte[7] & chp & ~cursor & blink_enabled;
    if (!mode_cga) begin
      ul   = (att_byte[2:0] == 3'd1) && (row_addr == 5'd12);
      nd   = (att_byte[2:0] == 3'd0) && (att_byte[6:4] == 3'd0);
      inv  = (att_byte[2:0] == 3'd0) && (att_byte[6:4] == 3'd7);
      dots = ((pix_in | ul) & ~nd & ~bl) | cb;
      p    = dots ^ inv;
      i    = dots ? att_byte[3] : (att_byte[7] & ~blink_enabled);
      c    = {i, p, p, p};
    end else begin
      dots = (pix_in & ~bl) | cb;
      c    = dots ? att_byte[3:0] : {att_byte[7] & ~blink_enabled, att_byte[6:4]};
      p    = dots;
      i    = c[3];
    end
    return {p, i, c};
  endfunction

  // Caller drives inputs after a falling edge; one clock is applied and outputs compared.
  task automatic step(input bit chk);
    logic [5:0] e;
    e = model_out(model_cphase(), model_chphase());
    @(posedge clk);
    edges   = edges + int'(pending);
    pending = (last_v == 1'b0) && (vsync == 1'b1);
    last_v  = vsync;
    #1;
    if (chk) begin
      check_eq("pix_out", pix_out, e[5]);
      check_eq("intensity_out", intensity_out, e[4]);
      check_eq("rgbi_out", rgbi_out, e[3:0]);
      check_eq("cursor_phase", cursor_phase, model_cphase());
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    edges   = 0;
    pending = 1'b0;
    last_v  = 1'b0;
  endtask

  task automatic vs_pulses(input int n);
    for (int k = 0; k < n; k++) begin
      vsync = 1'b1;
      repeat (3) step(1'b1);
      vsync = 1'b0;
      repeat (2) step(1'b1);
    end
  endtask

  initial begin
    reset = 1'b1; mode_cga = 1'b0; att_byte = 8'h07; row_addr = '0; display_enable = 1'b1;
    blink_enabled = 1'b1; vsync = 1'b0; cursor = 1'b0; pix_in = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_eq("reset_pix", pix_out, 1'b0);
    check_eq("reset_rgbi", rgbi_out, 4'h0);
    check_eq("reset_cphase", cursor_phase, 1'b0);
    reset = 1'b0;

    // MDA underline and inverse
    att_byte = 8'h01; row_addr = 5'd12; pix_in = 1'b0;
    step(1'b1);
    check_eq("mda_underline", pix_out, 1'b1);
    att_byte = 8'h70; pix_in = 1'b1;
    step(1'b1);
    check_eq("mda_inverse", pix_out, 1'b0);
    // MDA nodisp and bright
    att_byte = 8'h00;
    step(1'b1);
    check_eq("mda_nodisp", pix_out, 1'b0);
    att_byte = 8'h0F;
    step(1'b1);
    check_eq("mda_bright_pix", pix_out, 1'b1);
    check_eq("mda_bright_int", intensity_out, 1'b1);
    check_eq("mda_bright_rgbi", rgbi_out, 4'hF);
    // CGA colours
    mode_cga = 1'b1; att_byte = 8'h1E; pix_in = 1'b1;
    step(1'b1);
    check_eq("cga_fg", rgbi_out, 4'hE);
    pix_in = 1'b0;
    step(1'b1);
    check_eq("cga_bg", rgbi_out, 4'h1);
    att_byte = 8'h9E; blink_enabled = 1'b0;
    step(1'b1);
    check_eq("cga_bg_bright", rgbi_out, 4'h9);

    // Blink timing
    mode_cga = 1'b0; blink_enabled = 1'b1; att_byte = 8'h07; pix_in = 1'b1;
    vs_pulses(7);
    check_eq("cphase_7_edges", cursor_phase, 1'b0);
    vs_pulses(1);
    check_eq("cphase_8_edges", cursor_phase, 1'b1);
    vs_pulses(16);
    check_eq("cphase_24_edges", cursor_phase, 1'b1);
    att_byte = 8'h87; cursor = 1'b0; pix_in = 1'b1;
    step(1'b1);
    check_eq("char_blink_off", pix_out, 1'b0);
    cursor = 1'b1;
    step(1'b1);
    check_eq("cursor_over_blink", pix_out, 1'b1);
    display_enable = 1'b0;
    step(1'b1);
    check_eq("de_blank_pix", pix_out, 1'b0);
    check_eq("de_blank_rgbi", rgbi_out, 4'h0);

    // Asynchronous reset mid-cycle
    display_enable = 1'b1; cursor = 1'b0; att_byte = 8'h0F; pix_in = 1'b1;
    step(1'b1);
    #2 reset = 1'b1;
    #1;
    check_eq("async_rst_pix", pix_out, 1'b0);
    check_eq("async_rst_int", intensity_out, 1'b0);
    check_eq("async_rst_rgbi", rgbi_out, 4'h0);
    check_eq("async_rst_cphase", cursor_phase, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step(1'b1);
    check_eq("post_rst_pix", pix_out, 1'b1);

    // Random stimulus
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 5))
        0:       att_byte = 8'h00;
        1:       att_byte = 8'h70 | 8'($urandom_range(0, 1) << 7);
        2:       att_byte = 8'h01 | 8'($urandom_range(0, 255) & 8'hF8);
        default: att_byte = 8'($urandom());
      endcase
      row_addr       = ($urandom_range(0, 3) == 0) ? 5'd12 : 5'($urandom_range(0, 31));
      pix_in         = 1'($urandom());
      cursor         = ($urandom_range(0, 3) == 0);
      display_enable = ($urandom_range(0, 7) != 0);
      blink_enabled  = 1'($urandom());
      mode_cga       = 1'($urandom());
      if ($urandom_range(0, 3) == 0) vsync = ~vsync;
      step(1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
